dmem_arbiter: RTL and testbench

- Arbitrates the single-port data memory (dmem) between two requesters: the processor core's load/store path (port 0) and a DMA/debug master (port 1).
- Sits between the core datapath and the data memory instance. Grants at most one access per cycle.
- Returns read data one cycle after grant, with fair round-robin selection and a bounded DMA lock (burst) mode.

---
 rtl/dmem_arbiter.sv | 70 +++++++
 tb/tb_dmem_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter for one data-memory port, with a bounded DMA burst lock.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, CORE, DMA} owner_t;
  owner_t owner;
  logic last_rr;
  logic [7:0] burst_cnt;
  logic core_rv_q, dma_rv_q;
  logic [DATA_W-1:0] core_rd_q, dma_rd_q;
  logic tie, locked, sel_dma;
  always_comb begin
    tie = core_req & dma_req;
    locked = tie & (owner == DMA) & dma_lock & (burst_cnt < 8'(MAX_BURST));
    sel_dma = dma_req & (!core_req | locked | !last_rr);
    dma_gnt = !reset & sel_dma;
    core_gnt = !reset & core_req & !sel_dma;
    mem_addr = dma_gnt ? dma_addr : core_gnt ? core_addr : '0;
    mem_wdata = dma_gnt ? dma_wdata : core_gnt ? core_wdata : '0;
    mem_we = (dma_gnt & dma_we) | (core_gnt & core_we);
    // a read captured just before reset is hidden while reset is high
    core_rvalid = core_rv_q & !reset;
    dma_rvalid = dma_rv_q & !reset;
    core_rdata = reset ? '0 : core_rd_q;
    dma_rdata = reset ? '0 : dma_rd_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= IDLE;
      last_rr <= 1'b1;
      burst_cnt <= '0;
      core_rv_q <= 1'b0;
      dma_rv_q <= 1'b0;
      core_rd_q <= '0;
      dma_rd_q <= '0;
    end else begin
      owner <= dma_gnt ? DMA : core_gnt ? CORE : IDLE;
      if (tie & !locked) last_rr <= dma_gnt;
      burst_cnt <= (dma_gnt & dma_lock) ? ((owner == DMA) ? burst_cnt + 8'(burst_cnt != 8'hff) : 8'd1) : 8'd0;
      core_rv_q <= core_gnt & !core_we;
      dma_rv_q <= dma_gnt & !dma_we;
      if (core_gnt & !core_we) core_rd_q <= mem_rdata;
      if (dma_gnt & !dma_we) dma_rd_q <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors; read data scoreboarded by a monitor on rvalid.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic core_req = 0, core_we = 0, dma_req = 0, dma_we = 0, dma_lock = 0;
  logic [31:0] core_addr = 0, core_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic core_gnt, core_rvalid, dma_gnt, dma_rvalid, mem_we;
  logic [31:0] core_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  typedef struct {logic [31:0] d; int c;} exp_t;
  exp_t cq[$], dq[$];
  exp_t ce, de;
  int checks = 0, passes = 0, cyc_n = 0;
  bit track = 1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic cyc(input string nm, input logic cr, cw, input logic [31:0] ca, cd,
                     input logic dr, dw, dl, input logic [31:0] da, dd, input logic ec, ed);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    dma_req = dr; dma_we = dw; dma_lock = dl; dma_addr = da; dma_wdata = dd;
    #1;
    chk({nm, "_core_gnt"}, core_gnt, ec);
    chk({nm, "_dma_gnt"}, dma_gnt, ed);
    chk({nm, "_one_gnt"}, core_gnt & dma_gnt, 0);
    chk({nm, "_mem_we"}, mem_we, (ec & cw) | (ed & dw));
    chk({nm, "_mem_addr"}, mem_addr, ed ? da : ec ? ca : 32'h0);
    chk({nm, "_mem_wdata"}, mem_wdata, ed ? dd : ec ? cd : 32'h0);
    if (ec) begin
      if (cw) ref_mem[ca[7:0]] = cd;
      else if (track) cq.push_back('{ref_mem[ca[7:0]], cyc_n});
    end
    if (ed) begin
      if (dw) ref_mem[da[7:0]] = dd;
      else if (track) dq.push_back('{ref_mem[da[7:0]], cyc_n});
    end
    @(posedge clk); #1;
  endtask
  always @(negedge clk) begin
    if (core_rvalid) begin
      if (cq.size() == 0) chk("core_rvalid_unexpected", 1, 0);
      else begin
        ce = cq.pop_front();
        chk("core_rdata", core_rdata, ce.d);
        chk("core_rvalid_latency", cyc_n, ce.c + 1);
      end
    end
    if (dma_rvalid) begin
      if (dq.size() == 0) chk("dma_rvalid_unexpected", 1, 0);
      else begin
        de = dq.pop_front();
        chk("dma_rdata", dma_rdata, de.d);
        chk("dma_rvalid_latency", cyc_n, de.c + 1);
      end
    end
  end
  initial begin
    logic [6:0] lock_pat;
    int di;
    lock_pat = 7'b1101111;
    @(posedge clk); #1;
    cyc("rst0", 1, 0, 32'h10, 0, 1, 0, 0, 32'h24, 0, 0, 0);
    cyc("rst1", 1, 0, 32'h10, 0, 1, 0, 0, 32'h24, 0, 0, 0);
    chk("rst_core_rvalid", core_rvalid, 0);
    chk("rst_dma_rvalid", dma_rvalid, 0);
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_dma_rdata", dma_rdata, 0);
    reset = 0;
    cyc("first_tie", 1, 1, 32'h20, 32'h11111111, 1, 1, 0, 32'h24, 32'h22222222, 1, 0);
    cyc("dma_held", 0, 0, 0, 0, 1, 1, 0, 32'h24, 32'h22222222, 0, 1);
    cyc("core_store", 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0);
    cyc("core_load", 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("tie_dma", 1, 0, 32'h20, 0, 1, 0, 0, 32'h24, 0, 0, 1);
    cyc("core_held", 1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 1, 0);
    di = 0;
    for (int i = 0; i < 8; i++) begin
      cyc("rr", 1, 0, 32'h10, 0, 1, 1, 0, 32'h40 + di, 32'hA0 + di, i % 2 == 0, i % 2 == 1);
      if (i % 2 == 1) di++;
    end
    for (int i = 0; i < 4; i++) cyc("dma_rdback", 0, 0, 0, 0, 1, 0, 0, 32'h40 + i, 0, 0, 1);
    di = 0;
    for (int i = 0; i < 7; i++) begin
      cyc("lock", 1, 0, 32'h10, 0, 1, 1, 1, 32'h80 + di, 32'hB0 + di, !lock_pat[i], lock_pat[i]);
      if (lock_pat[i]) di++;
    end
    for (int i = 0; i < 10; i++) cyc("lock_solo", 0, 0, 0, 0, 1, 1, 1, 32'h90 + i, 32'hC0 + i, 0, 1);
    cyc("dma_load", 0, 0, 0, 0, 1, 0, 0, 32'h80, 0, 0, 1);
    track = 0;
    cyc("cut_load", 0, 0, 0, 0, 1, 0, 0, 32'h81, 0, 0, 1);
    track = 1;
    reset = 1;
    #1;
    chk("cut_dma_rvalid", dma_rvalid, 0);
    chk("cut_dma_rdata", dma_rdata, 0);
    cyc("cut_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 0;
    chk("post_rst_dma_rvalid", dma_rvalid, 0);
    chk("post_rst_dma_rdata", dma_rdata, 0);
    cyc("post_rst_tie", 1, 0, 32'h10, 0, 1, 0, 0, 32'h24, 0, 1, 0);
    cyc("drain0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("drain1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("core_pending", cq.size(), 0);
    chk("dma_pending", dq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
